serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder.
// One operand bit pair is consumed per clock, LSB first, so an addition of
// WIDTH-bit operands takes WIDTH cycles in ADD plus one DONE cycle.
// sum/cout are only updated on the edge that enters DONE, so downstream logic
// always sees a complete, stable result between done pulses.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter only needs to reach WIDTH-1; $clog2 gives at least 1 bit for WIDTH>=2.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;      // operand A shift register, LSB is the current bit
  logic [WIDTH-1:0] b_q;      // operand B shift register, LSB is the current bit
  logic [WIDTH-1:0] res_q;    // working result, sum bits enter at the MSB
  logic             c_q;      // running carry between bit positions
  logic [CW-1:0]    cnt_q;    // index of the bit processed on the next edge
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  // Full adder for the current bit position and the shifted working result.
  logic             s_d;
  logic             c_d;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  assign s_d      = a_q[0] ^ b_q[0] ^ c_q;
  assign c_d      = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign res_d    = {s_d, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == LAST_BIT);

  // Control FSM and datapath; reset wins over everything, including a running add.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= cin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            // After WIDTH shifts the first sum bit has arrived at bit 0.
            sum_q   <= res_d;
            cout_q  <= c_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Start is deliberately not looked at here; it is honoured in IDLE.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): directed cases plus random additions
// checked against a plain-arithmetic reference ({cout,sum} = a + b + cin).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int accepted = 0;

  // Reference model state: the last completed result as the outputs should show it.
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Count done pulses; sampled at the edge that ends the pulse cycle.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One addition starting at an IDLE negedge. mid < 0: inputs quiet during ADD;
  // mid == 0: random start/operand noise during ADD; mid > 0: start with a=FF at that cycle.
  task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input int mid);
    logic [W:0] exp;
    int         cyc;
    bit         seen;
    exp   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    @(negedge clk);
    accepted++;
    start = 1'b0;
    a     = W'($urandom_range(0, (1 << W) - 1));
    b     = W'($urandom_range(0, (1 << W) - 1));
    cin   = 1'($urandom_range(0, 1));
    cyc   = 0;
    seen  = 0;
    while (!seen && cyc <= 4 * W) begin
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        chk("busy_add", {63'd0, busy}, 64'd1);
        chk("sum_hold", {{(64-W){1'b0}}, sum}, {{(64-W){1'b0}}, m_sum});
        chk("cout_hold", {63'd0, cout}, {63'd0, m_cout});
        if (mid > 0) begin
          start = (cyc + 1 == mid);
          if (cyc + 1 == mid) a = '1;
        end else if (mid == 0) begin
          start = 1'($urandom_range(0, 1));
          a     = W'($urandom_range(0, (1 << W) - 1));
          b     = W'($urandom_range(0, (1 << W) - 1));
          cin   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
      start = 1'b0;
    end else begin
      m_sum  = exp[W-1:0];
      m_cout = exp[W];
      chk("latency", 64'(cyc), 64'(W));
      chk("busy_done", {63'd0, busy}, 64'd1);
      chk("sum", {{(64-W){1'b0}}, sum}, {{(64-W){1'b0}}, m_sum});
      chk("cout", {63'd0, cout}, {63'd0, m_cout});
      start = 1'b0;
      @(negedge clk);
      chk("done_pulse", {63'd0, done}, 64'd0);
      chk("busy_idle", {63'd0, busy}, 64'd0);
      chk("sum_after", {{(64-W){1'b0}}, sum}, {{(64-W){1'b0}}, m_sum});
      $display("add a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", av, bv, cv, sum, cout);
    end
  endtask

  initial begin
    int base;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    chk("rst_sum", {{(64-W){1'b0}}, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Start sampled together with reset must be ignored.
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h55;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", {63'd0, busy}, 64'd0);

    // Directed additions.
    do_add(8'h0F, 8'h01, 1'b0, -1);
    do_add(8'hFF, 8'h01, 1'b0, -1);
    do_add(8'hFF, 8'hFF, 1'b1, -1);
    do_add(8'h12, 8'h34, 1'b0, 3);
    base = done_cnt;
    repeat (3) @(negedge clk);
    chk("no_queued_done", 64'(done_cnt - base), 64'd0);

    // Start held high: two back-to-back additions, done at the earliest cycles.
    start = 1'b1;
    a     = 8'h03;
    b     = 8'h04;
    cin   = 1'b0;
    for (int i = 1; i <= 2 * W + 3; i++) begin
      @(negedge clk);
      if (i == W + 1 || i == 2 * W + 3) begin
        chk("b2b_done", {63'd0, done}, 64'd1);
        chk("b2b_sum", {{(64-W){1'b0}}, sum}, 64'h07);
      end else begin
        chk("b2b_nodone", {63'd0, done}, 64'd0);
      end
    end
    accepted += 2;
    m_sum  = 8'h07;
    m_cout = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {63'd0, busy}, 64'd0);
    $display("held-start back-to-back 03+04 x2 -> sum=%02h", sum);

    // Reset during the 4th ADD cycle aborts the addition.
    start = 1'b1;
    a     = 8'hA5;
    b     = 8'h3C;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = done_cnt;
    chk("abort_sum", {{(64-W){1'b0}}, sum}, 64'd0);
    chk("abort_cout", {63'd0, cout}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    m_sum  = '0;
    m_cout = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - base), 64'd0);
    $display("abort by reset -> sum=%02h cout=%0d", sum, cout);
    do_add(8'h01, 8'h01, 1'b1, -1);

    // Random additions with random idle gaps and noise during ADD.
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_add(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
             1'($urandom_range(0, 1)), 0);
    end

    repeat (2) @(negedge clk);
    chk("done_count", 64'(done_cnt), 64'(accepted));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
